// File: rtl/cpu_pkg.sv
// Shared datapath defaults and the register-file exchange state encoding.
package cpu_pkg;

    localparam int DW_DEF     = 8;
    localparam int NREG_DEF   = 4;
    localparam int IR_W_DEF   = 16;
    localparam int RX_LSB_DEF = 10;
    localparam int RY_LSB_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2
    } xchg_state_t;

endpackage

// File: rtl/regfile_xy.sv
// NREG x DW register file: two IR-selected registered read ports with write
// bypass, one write port, and a two-cycle RX<->RY exchange sequenced by an FSM.
module regfile_xy
    import cpu_pkg::*;
#(
    parameter int DW     = DW_DEF,
    parameter int NREG   = NREG_DEF,
    parameter int IR_W   = IR_W_DEF,
    parameter int RX_LSB = RX_LSB_DEF,
    parameter int RY_LSB = RY_LSB_DEF,
    localparam int AW    = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [IR_W-1:0] ir,
    input  logic            ir_valid,
    output logic            ir_ready,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [DW-1:0]   wr_data,
    output logic            wr_ready,
    input  logic            xchg_req,
    output logic            busy,
    output logic            xchg_done,
    output logic [DW-1:0]   rx_data,
    output logic [DW-1:0]   ry_data,
    output xchg_state_t     dbg_state
);

    // Handshake: ir_valid/wr_en/xchg_req are acted on only at an edge where
    // the matching ready (ir_ready/wr_ready, i.e. !busy) is high; nothing is queued.

    xchg_state_t   state_q, state_d;
    logic [DW-1:0] reg_q [NREG];
    logic [DW-1:0] reg_d [NREG];
    logic [AW-1:0] rx_sel_q, rx_sel_d, ry_sel_q, ry_sel_d;
    logic [DW-1:0] tmp_x_q, tmp_x_d, tmp_y_q, tmp_y_d;
    logic [DW-1:0] rx_data_q, rx_data_d, ry_data_q, ry_data_d;
    logic          done_q, done_d;
    logic          rx_ok, ry_ok;
    logic          unused_ir;

    assign unused_ir = ^ir;

    always_comb begin
        rx_ok = 1'b0;
        ry_ok = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            if (rx_sel_q == AW'(i)) rx_ok = 1'b1;
            if (ry_sel_q == AW'(i)) ry_ok = 1'b1;
        end
    end

    always_comb begin
        state_d  = state_q;
        reg_d    = reg_q;
        rx_sel_d = rx_sel_q;
        ry_sel_d = ry_sel_q;
        tmp_x_d  = tmp_x_q;
        tmp_y_d  = tmp_y_q;
        done_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (ir_valid) begin
                    rx_sel_d = ir[RX_LSB +: AW];
                    ry_sel_d = ir[RY_LSB +: AW];
                end
                for (int i = 0; i < NREG; i++) begin
                    if (wr_en && wr_addr == AW'(i)) reg_d[i] = wr_data;
                end
                if (xchg_req) state_d = RD;
            end
            RD: begin
                tmp_x_d = '0;
                tmp_y_d = '0;
                for (int i = 0; i < NREG; i++) begin
                    if (rx_sel_q == AW'(i)) tmp_x_d = reg_q[i];
                    if (ry_sel_q == AW'(i)) tmp_y_d = reg_q[i];
                end
                state_d = WR;
            end
            WR: begin
                // An out-of-range select cancels the whole swap.
                if (rx_ok && ry_ok) begin
                    for (int i = 0; i < NREG; i++) begin
                        if (ry_sel_q == AW'(i)) reg_d[i] = tmp_x_q;
                        if (rx_sel_q == AW'(i)) reg_d[i] = tmp_y_q;
                    end
                end
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Reading the next-state array gives bypass of same-edge writes for free.
    always_comb begin
        rx_data_d = '0;
        ry_data_d = '0;
        for (int i = 0; i < NREG; i++) begin
            if (rx_sel_d == AW'(i)) rx_data_d = reg_d[i];
            if (ry_sel_d == AW'(i)) ry_data_d = reg_d[i];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            for (int i = 0; i < NREG; i++) reg_q[i] <= '0;
            rx_sel_q  <= '0;
            ry_sel_q  <= '0;
            tmp_x_q   <= '0;
            tmp_y_q   <= '0;
            rx_data_q <= '0;
            ry_data_q <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            reg_q     <= reg_d;
            rx_sel_q  <= rx_sel_d;
            ry_sel_q  <= ry_sel_d;
            tmp_x_q   <= tmp_x_d;
            tmp_y_q   <= tmp_y_d;
            rx_data_q <= rx_data_d;
            ry_data_q <= ry_data_d;
            done_q    <= done_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign ir_ready  = !busy;
    assign wr_ready  = !busy;
    assign xchg_done = done_q;
    assign rx_data   = rx_data_q;
    assign ry_data   = ry_data_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_regfile_xy.sv
// Bench for regfile_xy: a 4-register and a 6-register instance share one input
// stream and are checked every cycle against an array-based model, plus literal checks.
module tb_regfile_xy;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] ir;
    logic        ir_valid, wr_en, xchg_req;
    logic [2:0]  wr_addr3;
    logic [7:0]  wr_data;

    logic        a_ir_ready, a_wr_ready, a_busy, a_done;
    logic [7:0]  a_rx, a_ry;
    xchg_state_t a_state;
    logic        b_ir_ready, b_wr_ready, b_busy, b_done;
    logic [7:0]  b_rx, b_ry;
    xchg_state_t b_state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    regfile_xy #(.DW(8), .NREG(4), .IR_W(16), .RX_LSB(10), .RY_LSB(8)) u_a (
        .clk(clk), .rst(rst), .ir(ir), .ir_valid(ir_valid), .ir_ready(a_ir_ready),
        .wr_en(wr_en), .wr_addr(wr_addr3[1:0]), .wr_data(wr_data), .wr_ready(a_wr_ready),
        .xchg_req(xchg_req), .busy(a_busy), .xchg_done(a_done),
        .rx_data(a_rx), .ry_data(a_ry), .dbg_state(a_state)
    );

    regfile_xy #(.DW(8), .NREG(6), .IR_W(16), .RX_LSB(11), .RY_LSB(8)) u_b (
        .clk(clk), .rst(rst), .ir(ir), .ir_valid(ir_valid), .ir_ready(b_ir_ready),
        .wr_en(wr_en), .wr_addr(wr_addr3), .wr_data(wr_data), .wr_ready(b_wr_ready),
        .xchg_req(xchg_req), .busy(b_busy), .xchg_done(b_done),
        .rx_data(b_rx), .ry_data(b_ry), .dbg_state(b_state)
    );

    // ---------------- behavioural model (index 0 = u_a, 1 = u_b) ----------------
    int         m_nreg [2] = '{4, 6};
    int         m_mask [2] = '{3, 7};
    int         m_rxl  [2] = '{10, 11};
    int         m_ryl  [2] = '{8, 8};
    logic [7:0] m_reg  [2][8];
    int         m_rx [2], m_ry [2], m_phase [2], m_left [2];
    logic [7:0] m_tx [2], m_ty [2], m_rxd [2], m_ryd [2];
    bit         m_done [2];
    bit         m_live = 1'b0;

    function automatic logic [7:0] m_read(int k, int a);
        return (a < m_nreg[k]) ? m_reg[k][a] : 8'h00;
    endfunction

    function automatic void cmp(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    task automatic model_step();
        int wa;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                for (int r = 0; r < 8; r++) m_reg[k][r] = 8'h00;
                m_rx[k] = 0; m_ry[k] = 0; m_phase[k] = 0; m_done[k] = 1'b0;
            end else if (m_phase[k] == 0) begin
                if (ir_valid) begin
                    m_rx[k] = (int'(ir) >> m_rxl[k]) & m_mask[k];
                    m_ry[k] = (int'(ir) >> m_ryl[k]) & m_mask[k];
                end
                wa = int'(wr_addr3) & m_mask[k];
                if (wr_en && wa < m_nreg[k]) m_reg[k][wa] = wr_data;
                m_phase[k] = xchg_req ? 1 : 0;
                m_done[k]  = 1'b0;
            end else if (m_phase[k] == 1) begin
                m_tx[k] = m_read(k, m_rx[k]);
                m_ty[k] = m_read(k, m_ry[k]);
                m_phase[k] = 2;
                m_done[k]  = 1'b0;
            end else begin
                if (m_rx[k] < m_nreg[k] && m_ry[k] < m_nreg[k]) begin
                    m_reg[k][m_rx[k]] = m_ty[k];
                    m_reg[k][m_ry[k]] = m_tx[k];
                end
                m_phase[k] = 0;
                m_done[k]  = 1'b1;
            end
            m_rxd[k] = m_read(k, m_rx[k]);
            m_ryd[k] = m_read(k, m_ry[k]);
        end
        m_live = 1'b1;
    endtask

    // Model advances at each rising edge; outputs are compared 2 time units later.
    initial begin
        forever begin
            @(posedge clk);
            model_step();
            #2;
            if (m_live) begin
                cmp("a.rx_data",  a_rx,       m_rxd[0]);
                cmp("a.ry_data",  a_ry,       m_ryd[0]);
                cmp("a.busy",     a_busy,     m_phase[0] != 0);
                cmp("a.done",     a_done,     m_done[0]);
                cmp("a.ir_ready", a_ir_ready, m_phase[0] == 0);
                cmp("a.wr_ready", a_wr_ready, m_phase[0] == 0);
                cmp("b.rx_data",  b_rx,       m_rxd[1]);
                cmp("b.ry_data",  b_ry,       m_ryd[1]);
                cmp("b.busy",     b_busy,     m_phase[1] != 0);
                cmp("b.done",     b_done,     m_done[1]);
                cmp("b.ir_ready", b_ir_ready, m_phase[1] == 0);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ir_valid = 1'b0; wr_en = 1'b0; xchg_req = 1'b0;
    endtask

    task automatic do_write(input logic [2:0] addr, input logic [7:0] data);
        wr_en = 1'b1; wr_addr3 = addr; wr_data = data;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic load_ir(input logic [15:0] word);
        ir = word; ir_valid = 1'b1;
        tick();
        ir_valid = 1'b0;
    endtask

    // ---------------- stimulus with literal expectations ----------------
    initial begin
        rst = 1'b1; ir = 16'h0; wr_addr3 = 3'd0; wr_data = 8'h0;
        idle_inputs();
        tick(); tick();
        cmp("rst.rx", a_rx, 8'h00);
        cmp("rst.ry", a_ry, 8'h00);
        cmp("rst.ir_ready", a_ir_ready, 1'b1);
        cmp("rst.busy", a_busy, 1'b0);
        cmp("rst.done", a_done, 1'b0);
        rst = 1'b0;
        load_ir(16'h0100);
        cmp("rst.load.rx", a_rx, 8'h00);
        cmp("rst.load.ry", a_ry, 8'h00);

        do_write(3'd2, 8'hA5);
        do_write(3'd3, 8'h3C);
        load_ir(16'h0B00);
        cmp("rd.rx", a_rx, 8'hA5);
        cmp("rd.ry", a_ry, 8'h3C);

        do_write(3'd2, 8'h77);
        cmp("bypass.rx", a_rx, 8'h77);
        do_write(3'd2, 8'hA5);
        cmp("bypass.restore", a_rx, 8'hA5);

        xchg_req = 1'b1;
        tick();
        xchg_req = 1'b0;
        cmp("xchg.busy1", a_busy, 1'b1);
        cmp("xchg.wr_ready", a_wr_ready, 1'b0);
        wr_en = 1'b1; wr_addr3 = 3'd2; wr_data = 8'hEE;
        tick();
        cmp("xchg.busy2", a_busy, 1'b1);
        cmp("xchg.done_early", a_done, 1'b0);
        tick();
        wr_en = 1'b0;
        cmp("xchg.busy3", a_busy, 1'b0);
        cmp("xchg.done", a_done, 1'b1);
        cmp("xchg.rx", a_rx, 8'h3C);
        cmp("xchg.ry", a_ry, 8'hA5);
        tick();
        cmp("xchg.done_once", a_done, 1'b0);
        cmp("xchg.no_stalled_wr", a_rx, 8'h3C);

        do_write(3'd1, 8'h5A);
        ir = 16'h0500; ir_valid = 1'b1; xchg_req = 1'b1;
        tick();
        idle_inputs();
        cmp("same.busy1", a_busy, 1'b1);
        tick();
        cmp("same.busy2", a_busy, 1'b1);
        tick();
        cmp("same.done", a_done, 1'b1);
        cmp("same.rx", a_rx, 8'h5A);
        cmp("same.ry", a_ry, 8'h5A);

        ir = 16'h0B00; ir_valid = 1'b1; xchg_req = 1'b1;
        tick();
        idle_inputs();
        tick();
        rst = 1'b1;
        tick();
        cmp("midrst.busy", a_busy, 1'b0);
        cmp("midrst.done", a_done, 1'b0);
        rst = 1'b0;
        tick();
        cmp("midrst.no_pulse", a_done, 1'b0);
        load_ir(16'h0B00);
        cmp("midrst.r2", a_rx, 8'h00);
        cmp("midrst.r3", a_ry, 8'h00);

        do_write(3'd2, 8'h11);
        do_write(3'd7, 8'hFF);
        load_ir(16'h3A00);
        cmp("n6.rx_r7", b_rx, 8'h00);
        cmp("n6.ry_r2", b_ry, 8'h11);
        cmp("n4.wrap_r2", a_rx, 8'h11);
        xchg_req = 1'b1;
        tick();
        xchg_req = 1'b0;
        tick(); tick();
        cmp("n6.xchg_done", b_done, 1'b1);
        cmp("n6.xchg_rx", b_rx, 8'h00);
        cmp("n6.xchg_ry", b_ry, 8'h11);

        repeat (3000) begin
            rst      = ($urandom_range(0, 99) == 0);
            ir       = 16'($urandom);
            ir_valid = ($urandom_range(0, 2) == 0);
            wr_en    = ($urandom_range(0, 1) == 0);
            wr_addr3 = 3'($urandom_range(0, 7));
            wr_data  = 8'($urandom);
            xchg_req = ($urandom_range(0, 3) == 0);
            tick();
        end
        rst = 1'b0;
        idle_inputs();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
